// File: rtl/wshb_pattern_pkg.sv
// Shared types and constants for the Wishbone test-pattern slave.
package wshb_pattern_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StAck, StBurst} state_e;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;
  localparam logic [1:0] BteLinear  = 2'b00;

  function automatic logic [31:0] pixel_of(input logic [23:0] idx);
    return {8'h00, idx};
  endfunction

endpackage

// File: rtl/wshb_pattern_gen.sv
// Combinational word-index to pixel mapping used for read data and write checking.
module wshb_pattern_gen
  import wshb_pattern_pkg::*;
(
  input  logic [29:0] idx_i,
  output logic [31:0] pixel_o
);

  logic unused_hi;
  assign unused_hi = ^idx_i[29:24];

  assign pixel_o = pixel_of(idx_i[23:0]);

endmodule

// File: rtl/wshb_pattern_slave.sv
// Wishbone slave returning a deterministic pixel pattern, with classic and INCR bursts.
// Optional PATTERN_CHECK_EN macro enables counting of write words that differ from the pattern.
module wshb_pattern_slave
  import wshb_pattern_pkg::*;
#(
  parameter int unsigned HDISP       = 800,
  parameter int unsigned VDISP       = 480,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty,
  output logic [15:0] mismatch_cnt
);

  localparam logic [29:0] FrameWords = 30'(HDISP * VDISP);
  localparam logic [3:0]  WaitInit   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [29:0] idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] dat_q, dat_d;
  logic [29:0] gen_idx;
  logic [31:0] gen_pix;
  logic        beat, in_range, active;

  assign beat     = cyc & stb;
  assign in_range = idx_q < FrameWords;
  assign active   = (state_q == StAck) || (state_q == StBurst);
  assign ack      = active & beat & in_range & ~sys_rst;
  assign err      = active & beat & ~in_range & ~sys_rst;
  assign rty      = 1'b0;
  assign dat_sm   = dat_q;

  // Data register always loads the word that the next acknowledged beat will return.
  assign gen_idx = (state_q == StIdle) ? adr[31:2] :
                   (state_q == StWait) ? idx_q : idx_q + 30'd1;

  wshb_pattern_gen u_gen (
    .idx_i   (gen_idx),
    .pixel_o (gen_pix)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    unique case (state_q)
      StIdle: begin
        if (beat) begin
          idx_d = adr[31:2];
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StAck;
            dat_d   = gen_pix;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
          dat_d   = gen_pix;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        if (beat) begin
          if (cti == CtiIncr && bte == BteLinear && in_range) begin
            state_d = StBurst;
            idx_d   = idx_q + 30'd1;
            dat_d   = gen_pix;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBurst: begin
        if (beat) begin
          if (cti == CtiEob || !in_range) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 30'd1;
            dat_d = gen_pix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!cyc) state_d = StIdle;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
    end
  end

`ifdef PATTERN_CHECK_EN
  logic [31:0] exp_pix, byte_mask;
  logic [15:0] mm_q, mm_d;
  logic        unused_ok;

  assign unused_ok = ^adr[1:0];
  assign byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};

  wshb_pattern_gen u_check (
    .idx_i   (idx_q),
    .pixel_o (exp_pix)
  );

  always_comb begin
    mm_d = mm_q;
    if (ack && we && (((dat_ms ^ exp_pix) & byte_mask) != 32'd0) && (mm_q != 16'hFFFF)) begin
      mm_d = mm_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) mm_q <= '0;
    else         mm_q <= mm_d;
  end

  assign mismatch_cnt = mm_q;
`else
  logic unused_ok;
  assign unused_ok    = ^{adr[1:0], we, dat_ms, sel};
  assign mismatch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_wshb_pattern_slave.sv
// Directed self-checking bench for wshb_pattern_slave (800x480, one wait state).
module tb_wshb_pattern_slave;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err, rty;
  logic [15:0] mismatch_cnt;

  int vectors = 0;
  int miscompares = 0;

  wshb_pattern_slave #(
    .HDISP       (800),
    .VDISP       (480),
    .WAIT_STATES (1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cyc          (cyc),
    .stb          (stb),
    .we           (we),
    .adr          (adr),
    .dat_ms       (dat_ms),
    .sel          (sel),
    .cti          (cti),
    .bte          (bte),
    .dat_sm       (dat_sm),
    .ack          (ack),
    .err          (err),
    .rty          (rty),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  // Waits (bounded) for ack or err; lat counts cycles from the first stb cycle.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (ack || err) break;
      lat++;
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    idle_bus();
    adr = '0; dat_ms = '0; sel = 4'hF;
    next_cycle();
    @(negedge sys_clk);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (dat_sm !== 32'h0) begin miscompares++; $display("FAIL reset_dat got %h want 0", dat_sm); end
    vectors++; if (mismatch_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_mm got %h want 0", mismatch_cnt); end
    vectors++; if (rty !== 1'b0) begin miscompares++; $display("FAIL reset_rty got %b want 0", rty); end
    next_cycle();
    sys_rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_classic_read(input string tag);
    int lat;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; cti = 3'b000; bte = 2'b00;
    wait_resp(lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL %s_latency got %0d want 2", tag, lat); end
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL %s_ack got %b want 1", tag, ack); end
    vectors++; if (dat_sm !== 32'h4) begin miscompares++; $display("FAIL %s_data got %h want 00000004", tag, dat_sm); end
    next_cycle();
    stb = 1'b0;
    @(negedge sys_clk);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL %s_single_ack got %b want 0", tag, ack); end
    next_cycle();
    idle_bus();
    next_cycle();
  endtask

  task automatic test_burst();
    int lat;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; cti = 3'b010; bte = 2'b00;
    wait_resp(lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL burst_latency got %0d want 2", lat); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge sys_clk);
      vectors++;
      if (ack !== 1'b1 || dat_sm !== 32'h40 + 32'(k)) begin
        miscompares++;
        $display("FAIL burst_beat%0d got ack=%b dat=%h want ack=1 dat=%h", k, ack, dat_sm,
                 32'h40 + 32'(k));
      end
      next_cycle();
      if (k == 2) cti = 3'b111;
    end
    // Still requesting: an idle slave must not ack in this cycle.
    adr = 32'h10; cti = 3'b000;
    @(negedge sys_clk);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL burst_end_idle got ack=%b want 0", ack); end
    next_cycle();
    idle_bus();
    next_cycle();
  endtask

  task automatic test_burst_gap();
    int lat;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h200; cti = 3'b010; bte = 2'b00;
    wait_resp(lat);
    vectors++;
    if (lat !== 2 || dat_sm !== 32'h80) begin
      miscompares++; $display("FAIL gap_first got lat=%0d dat=%h want lat=2 dat=00000080", lat, dat_sm);
    end
    next_cycle();
    @(negedge sys_clk);
    vectors++;
    if (ack !== 1'b1 || dat_sm !== 32'h81) begin
      miscompares++; $display("FAIL gap_second got ack=%b dat=%h want ack=1 dat=00000081", ack, dat_sm);
    end
    next_cycle();
    stb = 1'b0;
    for (int g = 0; g < 2; g++) begin
      @(negedge sys_clk);
      vectors++;
      if (ack !== 1'b0 || dat_sm !== 32'h82) begin
        miscompares++;
        $display("FAIL gap_hold%0d got ack=%b dat=%h want ack=0 dat=00000082", g, ack, dat_sm);
      end
      next_cycle();
    end
    stb = 1'b1; cti = 3'b111;
    @(negedge sys_clk);
    vectors++;
    if (ack !== 1'b1 || dat_sm !== 32'h82) begin
      miscompares++; $display("FAIL gap_resume got ack=%b dat=%h want ack=1 dat=00000082", ack, dat_sm);
    end
    next_cycle();
    idle_bus();
    next_cycle();
  endtask

  task automatic test_range();
    int lat;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0017_7000; cti = 3'b000; bte = 2'b00;
    wait_resp(lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL range_err_latency got %0d want 2", lat); end
    vectors++;
    if (err !== 1'b1 || ack !== 1'b0) begin
      miscompares++; $display("FAIL range_err got err=%b ack=%b want err=1 ack=0", err, ack);
    end
    next_cycle();
    idle_bus();
    next_cycle();
    cyc = 1'b1; stb = 1'b1; adr = 32'h0017_6FFC;
    wait_resp(lat);
    vectors++;
    if (ack !== 1'b1 || err !== 1'b0 || lat !== 2) begin
      miscompares++; $display("FAIL range_last got ack=%b err=%b lat=%0d want ack=1 err=0 lat=2", ack, err, lat);
    end
    vectors++; if (dat_sm !== 32'h0005_DBFF) begin miscompares++; $display("FAIL range_last_data got %h want 0005dbff", dat_sm); end
    next_cycle();
    idle_bus();
    next_cycle();
  endtask

  task automatic test_write();
    int lat;
    logic [15:0] exp1;
`ifdef PATTERN_CHECK_EN
    exp1 = 16'd1;
`else
    exp1 = 16'd0;
`endif
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_ms = 32'h5; sel = 4'hF; cti = 3'b000;
    wait_resp(lat);
    vectors++;
    if (ack !== 1'b1 || lat !== 2) begin
      miscompares++; $display("FAIL write_ack got ack=%b lat=%0d want ack=1 lat=2", ack, lat);
    end
    next_cycle();
    idle_bus();
    @(negedge sys_clk);
    vectors++; if (mismatch_cnt !== exp1) begin miscompares++; $display("FAIL write_bad got %0d want %0d", mismatch_cnt, exp1); end
    next_cycle();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; dat_ms = 32'h4;
    wait_resp(lat);
    next_cycle();
    idle_bus();
    @(negedge sys_clk);
    vectors++; if (mismatch_cnt !== exp1) begin miscompares++; $display("FAIL write_good got %0d want %0d", mismatch_cnt, exp1); end
    next_cycle();
    // Unselected upper bytes differ, selected byte matches.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; dat_ms = 32'hFFFF_FF04; sel = 4'h1;
    wait_resp(lat);
    next_cycle();
    idle_bus();
    sel = 4'hF;
    @(negedge sys_clk);
    vectors++; if (mismatch_cnt !== exp1) begin miscompares++; $display("FAIL write_sel got %0d want %0d", mismatch_cnt, exp1); end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    int lat;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; cti = 3'b010; bte = 2'b00;
    wait_resp(lat);
    next_cycle();
    @(negedge sys_clk);
    vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL rstburst_beat2 got ack=%b want 1", ack); end
    #1 sys_rst = 1'b1;
    #1;
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rstburst_ack got %b want 0", ack); end
    vectors++; if (dat_sm !== 32'h0) begin miscompares++; $display("FAIL rstburst_dat got %h want 0", dat_sm); end
    vectors++; if (mismatch_cnt !== 16'h0) begin miscompares++; $display("FAIL rstburst_mm got %h want 0", mismatch_cnt); end
    next_cycle();
    idle_bus();
    next_cycle();
    sys_rst = 1'b0;
    next_cycle();
    test_classic_read("post_rst");
  endtask

  initial begin
    test_reset();
    test_classic_read("classic");
    test_burst();
    test_burst_gap();
    test_range();
    test_write();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
